aemb_wbarb: RTL and testbench

AEMB_WBARB -- requirements
Module: aemb_wbarb

---
 rtl/aemb_wbarb.sv | 131 +++++++++++++
 tb/tb_aemb_wbarb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aemb_wbarb.sv
// Two-master Wishbone arbiter: shares one bus between the instruction fetch
// port (I) and the data port (D). A tie goes to whichever requester was not
// served last. A bounded wait turns a silent slave into an ack plus tmo_o,
// so the CPU never stalls forever.
module aemb_wbarb #(
  parameter int AW  = 32,
  parameter int TMO = 16
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  // instruction fetch port
  input  logic          iwb_stb_i,
  input  logic [AW-1:0] iwb_adr_i,
  output logic          iwb_ack_o,
  // data port
  input  logic          dwb_stb_i,
  input  logic          dwb_we_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [AW-1:0] dwb_adr_i,
  input  logic [31:0]   dwb_dat_i,
  output logic          dwb_ack_o,
  // read data returned to both requesters
  output logic [31:0]   rd_dat_o,
  // shared bus
  output logic          mwb_cyc_o,
  output logic          mwb_stb_o,
  output logic          mwb_we_o,
  output logic [3:0]    mwb_sel_o,
  output logic [AW-1:0] mwb_adr_o,
  output logic [31:0]   mwb_dat_o,
  input  logic [31:0]   mwb_dat_i,
  input  logic          mwb_ack_i,
  // timeout event
  output logic          tmo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  // Count value seen on the last cycle a slave is allowed to answer in.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last_gnt;   // 0: I was served last, 1: D was served last
  logic [7:0] tmo_cnt;
  logic       granted;
  logic       gnt_stb;
  logic       tmo_hit;

  // Decode the grant: whether a requester owns the bus, whether it is still
  // asking, and whether this is the final cycle before a forced timeout.
  always_comb begin
    granted = (state == IGNT) || (state == DGNT);
    gnt_stb = 1'b0;
    if (state == IGNT) gnt_stb = iwb_stb_i;
    if (state == DGNT) gnt_stb = dwb_stb_i;
    tmo_hit = granted && gnt_stb && !mwb_ack_i && (tmo_cnt == TMO_LAST);
  end

  // Next-state: arbitrate in IDLE; leave a grant on ack, timeout or abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (iwb_stb_i && dwb_stb_i) state_nxt = last_gnt ? IGNT : DGNT;
        else if (iwb_stb_i)         state_nxt = IGNT;
        else if (dwb_stb_i)         state_nxt = DGNT;
      end
      IGNT, DGNT: begin
        if (!gnt_stb || mwb_ack_i || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, plus the last-grant flag that is updated on every new grant.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE) last_gnt <= (state_nxt == DGNT);
    end
  end

  // Timeout counter: held at zero outside a grant so every grant starts fresh.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i)      tmo_cnt <= 8'd0;
    else if (!granted)   tmo_cnt <= 8'd0;
    else if (!mwb_ack_i) tmo_cnt <= tmo_cnt + 8'd1;
  end

  // Bus mux and ack steering; everything is quiet in IDLE.
  always_comb begin
    mwb_cyc_o = 1'b0;
    mwb_stb_o = 1'b0;
    mwb_we_o  = 1'b0;
    mwb_sel_o = 4'h0;
    mwb_adr_o = '0;
    mwb_dat_o = 32'h0;
    iwb_ack_o = 1'b0;
    dwb_ack_o = 1'b0;
    case (state)
      IGNT: begin
        mwb_cyc_o = 1'b1;
        mwb_stb_o = iwb_stb_i;
        mwb_sel_o = 4'hF;
        mwb_adr_o = iwb_adr_i;
        iwb_ack_o = mwb_ack_i || tmo_hit;
      end
      DGNT: begin
        mwb_cyc_o = 1'b1;
        mwb_stb_o = dwb_stb_i;
        mwb_we_o  = dwb_we_i;
        mwb_sel_o = dwb_sel_i;
        mwb_adr_o = dwb_adr_i;
        mwb_dat_o = dwb_dat_i;
        dwb_ack_o = mwb_ack_i || tmo_hit;
      end
      default: ;
    endcase
    tmo_o    = tmo_hit;
    rd_dat_o = tmo_hit ? 32'h0 : mwb_dat_i;
  end

endmodule

// File: tb/tb_aemb_wbarb.sv
// Directed bench for aemb_wbarb: one task per scenario, expected values
// worked out by hand from the arbitration and timeout rules.
module tb_aemb_wbarb;

  localparam int AW = 32;

  logic          sys_clk_i;
  logic          sys_rst_i;
  logic          iwb_stb_i;
  logic [AW-1:0] iwb_adr_i;
  logic          iwb_ack_o;
  logic          dwb_stb_i;
  logic          dwb_we_i;
  logic [3:0]    dwb_sel_i;
  logic [AW-1:0] dwb_adr_i;
  logic [31:0]   dwb_dat_i;
  logic          dwb_ack_o;
  logic [31:0]   rd_dat_o;
  logic          mwb_cyc_o;
  logic          mwb_stb_o;
  logic          mwb_we_o;
  logic [3:0]    mwb_sel_o;
  logic [AW-1:0] mwb_adr_o;
  logic [31:0]   mwb_dat_o;
  logic [31:0]   mwb_dat_i;
  logic          mwb_ack_i;
  logic          tmo_o;

  logic ack_drive;
  logic zero_wait;
  int   checks;
  int   errors;

  // Slave model: either a zero-wait slave that answers any strobe, or a
  // hand-driven ack line.
  assign mwb_ack_i = zero_wait ? mwb_stb_o : ack_drive;

  aemb_wbarb #(.AW(AW), .TMO(16)) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
    .iwb_stb_i(iwb_stb_i), .iwb_adr_i(iwb_adr_i), .iwb_ack_o(iwb_ack_o),
    .dwb_stb_i(dwb_stb_i), .dwb_we_i(dwb_we_i), .dwb_sel_i(dwb_sel_i),
    .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_ack_o(dwb_ack_o),
    .rd_dat_o(rd_dat_o),
    .mwb_cyc_o(mwb_cyc_o), .mwb_stb_o(mwb_stb_o), .mwb_we_o(mwb_we_o),
    .mwb_sel_o(mwb_sel_o), .mwb_adr_o(mwb_adr_o), .mwb_dat_o(mwb_dat_o),
    .mwb_dat_i(mwb_dat_i), .mwb_ack_i(mwb_ack_i), .tmo_o(tmo_o)
  );

  // Free-running clock, period 10.
  initial begin
    sys_clk_i = 1'b0;
    forever #5 sys_clk_i = ~sys_clk_i;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    // Reset held with both requesters and the slave ack active.
    sys_rst_i = 1'b0; iwb_stb_i = 1'b1; dwb_stb_i = 1'b1; ack_drive = 1'b1;
    dwb_we_i = 1'b1; dwb_sel_i = 4'h5; dwb_adr_i = 32'h200; dwb_dat_i = 32'h11112222;
    iwb_adr_i = 32'h80;
    repeat (2) @(negedge sys_clk_i);
    #1;
    checks++;
    if ({mwb_cyc_o, mwb_stb_o, mwb_we_o, mwb_sel_o, iwb_ack_o, dwb_ack_o, tmo_o} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {mwb_cyc_o, mwb_stb_o, mwb_we_o, mwb_sel_o, iwb_ack_o, dwb_ack_o, tmo_o});
    end
    checks++;
    if (mwb_adr_o !== 32'h0 || mwb_dat_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus: adr %h dat %h expected 0", mwb_adr_o, mwb_dat_o);
    end
    // Release: D must win the first tie.
    @(negedge sys_clk_i);
    sys_rst_i = 1'b1; ack_drive = 1'b0;
    @(negedge sys_clk_i);
    #1;
    checks++;
    if ({mwb_cyc_o, mwb_we_o, dwb_ack_o} !== 3'b110 || mwb_adr_o !== 32'h200) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: cyc/we/dack %b adr %h expected 110 adr 200", {mwb_cyc_o, mwb_we_o, dwb_ack_o}, mwb_adr_o);
    end
    ack_drive = 1'b1;
    #1;
    checks++;
    if ({iwb_ack_o, dwb_ack_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_first_ack: i/d ack %b expected 01", {iwb_ack_o, dwb_ack_o});
    end
    @(negedge sys_clk_i);
    iwb_stb_i = 1'b0; dwb_stb_i = 1'b0; ack_drive = 1'b0;
    #1;
    checks++;
    if (mwb_cyc_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_return_idle: cyc %b expected 0", mwb_cyc_o);
    end
  endtask

  task automatic test_idle_ack();
    // A stray slave ack while idle must not reach either requester.
    @(negedge sys_clk_i);
    mwb_dat_i = 32'h5555AAAA; ack_drive = 1'b1;
    #1;
    checks++;
    if ({mwb_cyc_o, iwb_ack_o, dwb_ack_o, tmo_o} !== 4'b0 || rd_dat_o !== 32'h5555AAAA) begin
      errors++;
      $display("[TB] FAIL idle_ack: ctrl %b rd %h expected 0000 rd 5555aaaa", {mwb_cyc_o, iwb_ack_o, dwb_ack_o, tmo_o}, rd_dat_o);
    end
    ack_drive = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(negedge sys_clk_i);
    iwb_stb_i = 1'b1; iwb_adr_i = 32'h100; dwb_adr_i = 32'h300; dwb_dat_i = 32'hFFFF0000;
    @(negedge sys_clk_i);
    #1;
    checks++;
    if ({mwb_cyc_o, mwb_stb_o, mwb_we_o, mwb_sel_o, iwb_ack_o, dwb_ack_o} !== 9'b110_1111_00) begin
      errors++;
      $display("[TB] FAIL fetch_ctrl: got %b expected 110111100", {mwb_cyc_o, mwb_stb_o, mwb_we_o, mwb_sel_o, iwb_ack_o, dwb_ack_o});
    end
    checks++;
    if (mwb_adr_o !== 32'h100 || mwb_dat_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL fetch_bus: adr %h dat %h expected 100 / 0", mwb_adr_o, mwb_dat_o);
    end
    // Slave answers in the second granted cycle.
    @(negedge sys_clk_i);
    ack_drive = 1'b1; mwb_dat_i = 32'h12345678;
    #1;
    checks++;
    if ({iwb_ack_o, dwb_ack_o, tmo_o} !== 3'b100 || rd_dat_o !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL fetch_ack: i/d/tmo %b rd %h expected 100 rd 12345678", {iwb_ack_o, dwb_ack_o, tmo_o}, rd_dat_o);
    end
    @(negedge sys_clk_i);
    iwb_stb_i = 1'b0; ack_drive = 1'b0;
    #1;
    checks++;
    if ({mwb_cyc_o, iwb_ack_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL fetch_done: cyc/iack %b expected 00", {mwb_cyc_o, iwb_ack_o});
    end
  endtask

  task automatic test_tie();
    // Last served was I, so D goes first, then strict alternation.
    @(negedge sys_clk_i);
    dwb_we_i = 1'b0; iwb_stb_i = 1'b1; dwb_stb_i = 1'b1; zero_wait = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk_i);
      #1;
      checks++;
      if ({mwb_cyc_o, iwb_ack_o, dwb_ack_o} !== {k % 2 == 1, k % 4 == 3, k % 4 == 1}) begin
        errors++;
        $display("[TB] FAIL tie_cycle%0d: cyc/iack/dack %b expected %b", k, {mwb_cyc_o, iwb_ack_o, dwb_ack_o}, {k % 2 == 1, k % 4 == 3, k % 4 == 1});
      end
    end
    iwb_stb_i = 1'b0; dwb_stb_i = 1'b0; zero_wait = 1'b0;
  endtask

  task automatic test_timeout(input bit ack_at_limit);
    @(negedge sys_clk_i);
    mwb_dat_i = 32'hDEADBEEF; ack_drive = 1'b0; dwb_stb_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge sys_clk_i);
      if (k == 16 && ack_at_limit) ack_drive = 1'b1;
      #1;
      if (k < 16) begin
        checks++;
        if ({mwb_cyc_o, dwb_ack_o, tmo_o} !== 3'b100) begin
          errors++;
          $display("[TB] FAIL tmo_wait%0d: cyc/dack/tmo %b expected 100", k, {mwb_cyc_o, dwb_ack_o, tmo_o});
        end
      end else if (!ack_at_limit) begin
        checks++;
        if ({mwb_cyc_o, iwb_ack_o, dwb_ack_o, tmo_o} !== 4'b1011 || rd_dat_o !== 32'h0) begin
          errors++;
          $display("[TB] FAIL tmo_fire: cyc/iack/dack/tmo %b rd %h expected 1011 rd 0", {mwb_cyc_o, iwb_ack_o, dwb_ack_o, tmo_o}, rd_dat_o);
        end
      end else begin
        checks++;
        if ({dwb_ack_o, tmo_o} !== 2'b10 || rd_dat_o !== 32'hDEADBEEF) begin
          errors++;
          $display("[TB] FAIL tmo_with_ack: dack/tmo %b rd %h expected 10 rd deadbeef", {dwb_ack_o, tmo_o}, rd_dat_o);
        end
      end
    end
    @(negedge sys_clk_i);
    #1;
    checks++;
    if ({mwb_cyc_o, tmo_o, dwb_ack_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL tmo_release: cyc/tmo/dack %b expected 000", {mwb_cyc_o, tmo_o, dwb_ack_o});
    end
    dwb_stb_i = 1'b0; ack_drive = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge sys_clk_i);
    iwb_stb_i = 1'b1; iwb_adr_i = 32'h180;
    @(negedge sys_clk_i);
    #1;
    checks++;
    if ({mwb_cyc_o, mwb_stb_o} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL abort_grant: cyc/stb %b expected 11", {mwb_cyc_o, mwb_stb_o});
    end
    #1;
    iwb_stb_i = 1'b0;
    #1;
    checks++;
    if ({mwb_cyc_o, mwb_stb_o, iwb_ack_o, tmo_o} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL abort_drop: cyc/stb/iack/tmo %b expected 1000", {mwb_cyc_o, mwb_stb_o, iwb_ack_o, tmo_o});
    end
    @(negedge sys_clk_i);
    #1;
    checks++;
    if ({mwb_cyc_o, iwb_ack_o, dwb_ack_o, tmo_o} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL abort_idle: cyc/iack/dack/tmo %b expected 0000", {mwb_cyc_o, iwb_ack_o, dwb_ack_o, tmo_o});
    end
  endtask

  task automatic test_mid_reset();
    @(negedge sys_clk_i);
    dwb_stb_i = 1'b1; dwb_we_i = 1'b1; dwb_sel_i = 4'h3; dwb_adr_i = 32'h400; dwb_dat_i = 32'hCAFEF00D;
    @(negedge sys_clk_i);
    #1;
    checks++;
    if ({mwb_cyc_o, mwb_we_o, mwb_sel_o} !== 6'b11_0011 || mwb_adr_o !== 32'h400 || mwb_dat_o !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL write_bus: cyc/we/sel %b adr %h dat %h expected 110011 400 cafef00d", {mwb_cyc_o, mwb_we_o, mwb_sel_o}, mwb_adr_o, mwb_dat_o);
    end
    #1;
    sys_rst_i = 1'b0;
    #1;
    checks++;
    if ({mwb_cyc_o, mwb_stb_o, mwb_we_o, dwb_ack_o} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midreset_drop: cyc/stb/we/dack %b expected 0000", {mwb_cyc_o, mwb_stb_o, mwb_we_o, dwb_ack_o});
    end
    ack_drive = 1'b1;
    #1;
    checks++;
    if (dwb_ack_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_noack: dack %b expected 0", dwb_ack_o);
    end
    @(negedge sys_clk_i);
    #1;
    checks++;
    if ({mwb_cyc_o, dwb_ack_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midreset_hold: cyc/dack %b expected 00", {mwb_cyc_o, dwb_ack_o});
    end
    // Release with both requesting: last-grant was reset to I, so D wins.
    ack_drive = 1'b0; iwb_stb_i = 1'b1; sys_rst_i = 1'b1;
    @(negedge sys_clk_i);
    #1;
    checks++;
    if ({mwb_cyc_o, mwb_we_o} !== 2'b11 || mwb_adr_o !== 32'h400) begin
      errors++;
      $display("[TB] FAIL midreset_restart: cyc/we %b adr %h expected 11 adr 400", {mwb_cyc_o, mwb_we_o}, mwb_adr_o);
    end
    ack_drive = 1'b1;
    #1;
    checks++;
    if ({iwb_ack_o, dwb_ack_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL midreset_ack: i/d ack %b expected 01", {iwb_ack_o, dwb_ack_o});
    end
    @(negedge sys_clk_i);
    dwb_stb_i = 1'b0; iwb_stb_i = 1'b0; ack_drive = 1'b0;
    #1;
    checks++;
    if (mwb_cyc_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_end: cyc %b expected 0", mwb_cyc_o);
    end
  endtask

  // Scenario sequence.
  initial begin
    checks = 0; errors = 0;
    zero_wait = 1'b0; ack_drive = 1'b0; mwb_dat_i = 32'h0;
    sys_rst_i = 1'b0; iwb_stb_i = 1'b0; dwb_stb_i = 1'b0;
    iwb_adr_i = '0; dwb_adr_i = '0; dwb_we_i = 1'b0; dwb_sel_i = 4'h0; dwb_dat_i = 32'h0;
    test_reset();
    test_idle_ack();
    test_single_fetch();
    test_tie();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_abort();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
